// File: rtl/snn_pkg.sv
// Shared state encoding and default widths for the spiking-neuron blocks.
package snn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam int CNT_W_DEF = 8;
  localparam int WIN_W_DEF = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with sticky sat flag; 1-cycle update, never stalls.
// clr restarts the count and still honours an inc in the same cycle.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         sat
);

  localparam logic [W-1:0] MAX = '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (clr) begin
      cnt <= W'(inc);
      sat <= 1'b0;
    end else if (inc) begin
      // sat marks a spike that was lost because the count was already full
      if (cnt == MAX) sat <= 1'b1;
      else            cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/spike_window_counter.sv
// Counts spikes over back-to-back windows; result valid 1 cycle after the last window cycle,
// held while out_ready is low (a newer result is dropped and overrun set). SPIKE_ISI_EN adds min ISI.
module spike_window_counter
  import snn_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int WIN_W = WIN_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             spike,
  input  logic             enable,
  input  logic [WIN_W-1:0] window_len,
  output logic [CNT_W-1:0] out_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sat,
  output logic             overrun,
  output logic [WIN_W-1:0] min_isi,
  output logic             busy
);

  state_t           state;
  logic [WIN_W-1:0] len_q;
  logic [WIN_W-1:0] cyc;
  logic             cap_q;

  logic             act;
  logic             first;
  logic             last;
  logic [WIN_W-1:0] idx;
  logic [WIN_W-1:0] len_eff;

  logic [CNT_W-1:0] cnt;
  logic             cnt_sat;
  logic             hs;
  logic             load;

  // The start cycle in IDLE is already window cycle 1, so it is handled like any RUN cycle.
  // len-1 wraps to all ones for window_len 0, giving a 2^WIN_W cycle window.
  always_comb begin
    act     = (state == IDLE) ? enable : 1'b1;
    idx     = (state == IDLE) ? '0 : cyc;
    first   = act && (idx == '0);
    len_eff = first ? window_len : len_q;
    last    = act && (idx == len_eff - WIN_W'(1));
  end

  sat_counter #(.W(CNT_W)) u_spike_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (first),
    .inc   (act && spike),
    .cnt   (cnt),
    .sat   (cnt_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      len_q <= '0;
      cyc   <= '0;
      cap_q <= 1'b0;
    end else begin
      cap_q <= last;
      if (first) len_q <= window_len;
      if (act)   cyc   <= last ? '0 : idx + WIN_W'(1);
      case (state)
        IDLE: begin
          if (enable) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (last && !enable) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (!last && !enable) begin
            state <= STOP;
          end
        end
        STOP: begin
          if (last) begin
            state <= enable ? RUN : IDLE;
            busy  <= enable;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign hs   = out_valid && out_ready;
  assign load = cap_q && (!out_valid || hs);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_count <= '0;
      out_sat   <= 1'b0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (load) begin
        out_count <= cnt;
        out_sat   <= cnt_sat;
        out_valid <= 1'b1;
      end else if (hs) begin
        out_valid <= 1'b0;
      end
      if (cap_q && out_valid && !out_ready) overrun <= 1'b1;
    end
  end

`ifdef SPIKE_ISI_EN
  logic [WIN_W-1:0] last_spk;
  logic [WIN_W-1:0] isi_min;
  logic [WIN_W-1:0] isi;
  logic             have_spk;

  assign isi = idx - last_spk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_spk <= '0;
      isi_min  <= '1;
      have_spk <= 1'b0;
      min_isi  <= '0;
    end else begin
      if (first) begin
        have_spk <= spike;
        last_spk <= '0;
        isi_min  <= '1;
      end else if (act && spike) begin
        if (have_spk && (isi < isi_min)) isi_min <= isi;
        have_spk <= 1'b1;
        last_spk <= idx;
      end
      if (load) min_isi <= isi_min;
    end
  end
`else
  assign min_isi = '0;
`endif

endmodule

// File: tb/tb_spike_window_counter.sv
// Directed-vector bench for spike_window_counter; expected values are hand-derived per scenario.
module tb_spike_window_counter;

  localparam int CNT_W = 8;
  localparam int WIN_W = 8;
`ifdef SPIKE_ISI_EN
  localparam bit ISI_ON = 1'b1;
`else
  localparam bit ISI_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             spike;
  logic             enable;
  logic [WIN_W-1:0] window_len;
  logic [CNT_W-1:0] out_count;
  logic             out_valid;
  logic             out_ready;
  logic             out_sat;
  logic             overrun;
  logic [WIN_W-1:0] min_isi;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spike_window_counter #(.CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spike      (spike),
    .enable     (enable),
    .window_len (window_len),
    .out_count  (out_count),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sat    (out_sat),
    .overrun    (overrun),
    .min_isi    (min_isi),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    spike      = 1'b0;
    enable     = 1'b0;
    out_ready  = 1'b0;
    window_len = '0;
    tick();
    tick();
    chk("rst_valid",   32'(out_valid), 32'd0);
    chk("rst_count",   32'(out_count), 32'd0);
    chk("rst_sat",     32'(out_sat),   32'd0);
    chk("rst_overrun", 32'(overrun),   32'd0);
    chk("rst_busy",    32'(busy),      32'd0);
    chk("rst_min_isi", 32'(min_isi),   32'd0);
    rst_n = 1'b1;
    tick();

    // 10-cycle window, single-cycle enable, 4 spikes; valid exactly 10 edges after the start edge
    window_len = 8'd10;
    for (int k = 0; k <= 10; k++) begin
      enable = (k == 0);
      spike  = (k >= 3 && k <= 6);
      tick();
      chk($sformatf("w10_valid_%0d", k), 32'(out_valid), 32'(k == 10));
      chk($sformatf("w10_busy_%0d", k),  32'(busy),      32'(k <= 8));
    end
    spike = 1'b0;
    chk("w10_count", 32'(out_count), 32'd4);
    chk("w10_sat",   32'(out_sat),   32'd0);
    drain();
    chk("w10_drained", 32'(out_valid), 32'd0);

    // window_len 0 = 256 cycles, spike always high -> saturates
    window_len = 8'd0;
    spike      = 1'b1;
    enable     = 1'b1;
    tick();
    enable = 1'b0;
    for (int k = 1; k <= 256; k++) begin
      tick();
      if (k == 255) chk("w256_valid_early", 32'(out_valid), 32'd0);
    end
    spike = 1'b0;
    chk("w256_valid", 32'(out_valid), 32'd1);
    chk("w256_count", 32'(out_count), 32'd255);
    chk("w256_sat",   32'(out_sat),   32'd1);
    chk("w256_busy",  32'(busy),      32'd0);
    drain();

    // back-to-back 5-cycle windows, consumer stalled -> second result dropped
    window_len = 8'd5;
    for (int k = 0; k <= 15; k++) begin
      enable = (k <= 9);
      spike  = (k == 1 || k == 2 || k == 6 || k == 7 || k == 8);
      tick();
      case (k)
        4:  chk("ovr_valid_e4", 32'(out_valid), 32'd0);
        5: begin
          chk("ovr_valid_e5",   32'(out_valid), 32'd1);
          chk("ovr_count_e5",   32'(out_count), 32'd2);
          chk("ovr_overrun_e5", 32'(overrun),   32'd0);
        end
        10: begin
          chk("ovr_valid_e10",   32'(out_valid), 32'd1);
          chk("ovr_count_e10",   32'(out_count), 32'd2);
          chk("ovr_overrun_e10", 32'(overrun),   32'd1);
        end
        15: begin
          chk("ovr_count_e15", 32'(out_count), 32'd2);
          chk("ovr_busy_e15",  32'(busy),      32'd0);
        end
        default: ;
      endcase
    end
    spike = 1'b0;
    drain();
    chk("ovr_drained", 32'(out_valid), 32'd0);
    chk("ovr_sticky",  32'(overrun),   32'd1);
    rst_n = 1'b0;
    #1;
    chk("ovr_cleared", 32'(overrun), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // accept in the same cycle as the second capture -> new result loads, no overrun
    window_len = 8'd5;
    for (int k = 0; k <= 15; k++) begin
      enable    = (k <= 9);
      spike     = (k == 0 || k == 2 || k == 4 || k == 7 || k == 9);
      out_ready = (k == 10 || k == 11);
      tick();
      case (k)
        5: begin
          chk("hs_valid_e5", 32'(out_valid), 32'd1);
          chk("hs_count_e5", 32'(out_count), 32'd3);
        end
        10: begin
          chk("hs_valid_e10",   32'(out_valid), 32'd1);
          chk("hs_count_e10",   32'(out_count), 32'd2);
          chk("hs_overrun_e10", 32'(overrun),   32'd0);
        end
        11: chk("hs_valid_e11", 32'(out_valid), 32'd0);
        15: begin
          chk("hs_valid_e15",   32'(out_valid), 32'd1);
          chk("hs_count_e15",   32'(out_count), 32'd0);
          chk("hs_overrun_e15", 32'(overrun),   32'd0);
        end
        default: ;
      endcase
    end
    out_ready = 1'b0;
    spike     = 1'b0;
    drain();

    // enable dropped at window cycle 3 of 8 -> window still completes
    window_len = 8'd8;
    for (int k = 0; k <= 8; k++) begin
      enable = (k <= 1);
      spike  = (k == 3);
      tick();
      case (k)
        2: chk("stop_busy_e2", 32'(busy), 32'd1);
        6: chk("stop_busy_e6", 32'(busy), 32'd1);
        7: begin
          chk("stop_busy_e7",  32'(busy),      32'd0);
          chk("stop_valid_e7", 32'(out_valid), 32'd0);
        end
        8: begin
          chk("stop_valid_e8", 32'(out_valid), 32'd1);
          chk("stop_count_e8", 32'(out_count), 32'd1);
          chk("stop_sat_e8",   32'(out_sat),   32'd0);
        end
        default: ;
      endcase
    end
    spike = 1'b0;
    drain();

    // reset during window cycle 4 abandons the window
    enable = 1'b1;
    spike  = 1'b1;
    for (int k = 0; k <= 2; k++) tick();
    chk("abort_busy_pre", 32'(busy), 32'd1);
    rst_n  = 1'b0;
    enable = 1'b0;
    spike  = 1'b0;
    #1;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_busy",  32'(busy),      32'd0);
    chk("abort_count", 32'(out_count), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) tick();
    chk("abort_no_result", 32'(out_valid), 32'd0);
    chk("abort_idle",      32'(busy),      32'd0);

    // minimum inter-spike interval: spikes at window cycles 2, 7, 9
    window_len = 8'd20;
    for (int k = 0; k <= 20; k++) begin
      enable = (k == 0);
      spike  = (k == 1 || k == 6 || k == 8);
      tick();
    end
    spike = 1'b0;
    chk("isi_valid", 32'(out_valid), 32'd1);
    chk("isi_count", 32'(out_count), 32'd3);
    chk("isi_min",   32'(min_isi),   ISI_ON ? 32'd2 : 32'd0);
    drain();

    window_len = 8'd4;
    for (int k = 0; k <= 4; k++) begin
      enable = (k == 0);
      spike  = (k == 2);
      tick();
    end
    spike = 1'b0;
    chk("isi1_valid", 32'(out_valid), 32'd1);
    chk("isi1_count", 32'(out_count), 32'd1);
    chk("isi1_min",   32'(min_isi),   ISI_ON ? 32'd255 : 32'd0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
